// File: rtl/uart_rx_ctrl.sv
// UART receive controller: baud tick generator, line synchronizer,
// FWFT word FIFO with overflow flag, and line-break detector.
module uart_rx_ctrl #(
    parameter int DBIT      = 8,
    parameter int DVSR_W    = 11,
    parameter int FIFO_AW   = 2,
    parameter int BRK_TICKS = 160
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [DVSR_W-1:0]   dvsr,
    input  logic                rx_in,
    output logic                rx_sync,
    output logic                s_tick,
    input  logic                rx_done_tick,
    input  logic [DBIT-1:0]     rx_data,
    output logic [DBIT-1:0]     rd_data,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [FIFO_AW:0]    fifo_cnt,
    output logic                overflow,
    input  logic                clr_ovf,
    output logic                break_det
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int BW    = $clog2(BRK_TICKS);
    localparam logic [BW-1:0]    BRK_LAST = BW'(BRK_TICKS - 1);
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOW   = 2'd1;
    localparam logic [1:0] ST_BREAK = 2'd2;

    logic               r_sync1;
    logic               r_sync2;
    logic [DVSR_W-1:0]  r_baud_cnt;
    logic               r_tick;
    logic [DBIT-1:0]    r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_cnt;
    logic               r_ovf;
    logic [1:0]         r_state;
    logic [BW-1:0]      r_brk_cnt;

    logic               w_full;
    logic               w_empty;
    logic               w_push_req;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [BW-1:0]      w_brk_nxt;

    // Reset to idle-high so the detector never sees a false start bit
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_in;
            r_sync2 <= r_sync1;
        end
    end

    // >= lets a mid-count divisor decrease wrap at once
    always_ff @(posedge clk) begin
        if (!reset || !en) begin
            r_baud_cnt <= '0;
            r_tick     <= 1'b0;
        end else if (r_baud_cnt >= dvsr) begin
            r_baud_cnt <= '0;
            r_tick     <= 1'b1;
        end else begin
            r_baud_cnt <= r_baud_cnt + DVSR_W'(1);
            r_tick     <= 1'b0;
        end
    end

    assign w_full     = (r_cnt == FULL_CNT);
    assign w_empty    = (r_cnt == '0);
    assign w_push_req = rx_done_tick & en;
    assign w_pop      = rd_ready & ~w_empty;
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (reset && w_push) begin
            r_mem[r_wptr] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + FIFO_AW'(1);
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + (FIFO_AW + 1)'(1);
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - (FIFO_AW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    assign w_brk_nxt = r_brk_cnt + BW'(1);

    always_ff @(posedge clk) begin
        if (!reset || !en) begin
            r_state   <= ST_IDLE;
            r_brk_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_tick && !r_sync2) begin
                        r_state   <= ST_LOW;
                        r_brk_cnt <= '0;
                    end
                end
                ST_LOW: begin
                    if (r_sync2) begin
                        r_state <= ST_IDLE;
                    end else if (r_tick) begin
                        r_brk_cnt <= w_brk_nxt;
                        if (w_brk_nxt == BRK_LAST) begin
                            r_state <= ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    if (r_sync2) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rx_sync   = r_sync2;
    assign s_tick    = r_tick;
    assign rd_valid  = ~w_empty;
    assign rd_data   = w_empty ? '0 : r_mem[r_rptr];
    assign fifo_cnt  = r_cnt;
    assign overflow  = r_ovf;
    assign break_det = (r_state == ST_BREAK);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a FIFO scoreboard queue.
module tb_uart_rx_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [10:0] dvsr;
    logic        rx_in;
    logic        rx_sync;
    logic        s_tick;
    logic        rx_done_tick;
    logic [7:0]  rx_data;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [2:0]  fifo_cnt;
    logic        overflow;
    logic        clr_ovf;
    logic        break_det;

    int ntests = 0;
    int nfail  = 0;
    logic [7:0] q[$];
    logic       movf = 1'b0;

    always #5 clk = ~clk;

    uart_rx_ctrl dut (
        .clk(clk), .reset(reset), .en(en), .dvsr(dvsr),
        .rx_in(rx_in), .rx_sync(rx_sync), .s_tick(s_tick),
        .rx_done_tick(rx_done_tick), .rx_data(rx_data),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .fifo_cnt(fifo_cnt), .overflow(overflow), .clr_ovf(clr_ovf),
        .break_det(break_det)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of FIFO stimulus, called at a negedge
    task automatic cyc(input logic done, input logic [7:0] d,
                       input logic rdy, input logic clr);
        logic popped;
        popped = 1'b0;
        if (rdy && q.size() > 0) begin
            chk("pop_data", rd_data, q[0]);
            void'(q.pop_front());
            popped = 1'b1;
        end
        if (done && en) begin
            if (q.size() < 4) q.push_back(d);
            else movf = 1'b1;
        end else if (clr) begin
            movf = 1'b0;
        end
        if (done && en && q.size() == 4 && !popped && clr) movf = 1'b1;
        rx_done_tick = done;
        rx_data      = d;
        rd_ready     = rdy;
        clr_ovf      = clr;
        @(negedge clk);
        rx_done_tick = 1'b0;
        rd_ready     = 1'b0;
        clr_ovf      = 1'b0;
        chk("fifo_cnt", fifo_cnt, q.size());
        chk("rd_valid", rd_valid, q.size() != 0);
        chk("overflow", overflow, movf);
    endtask

    task automatic tick_run(input int ncyc, input int period);
        int first;
        int last;
        int nt;
        first = -1;
        last  = 0;
        nt    = 0;
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            if (s_tick) begin
                if (first < 0) first = i;
                else chk("tick_period", i - last, period);
                last = i;
                nt++;
            end
        end
        chk("tick_first", first, period);
        chk("tick_count", nt, ncyc / period);
    endtask

    initial begin
        int n;
        logic seen;
        reset = 1'b0; en = 1'b0; dvsr = 11'd650; rx_in = 1'b1;
        rx_done_tick = 1'b0; rx_data = 8'h00; rd_ready = 1'b0;
        clr_ovf = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rx_sync", rx_sync, 1'b1);
        chk("rst_s_tick", s_tick, 1'b0);
        chk("rst_fifo_cnt", fifo_cnt, 0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_break", break_det, 1'b0);
        reset = 1'b1;

        // baud generator
        en = 1'b1;
        tick_run(5000, 651);
        en = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (s_tick) seen = 1'b1;
        end
        chk("tick_en0", seen, 1'b0);
        en = 1'b1;
        tick_run(1400, 651);
        dvsr = 11'd0;
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        tick_run(10, 1);

        // FIFO order
        cyc(1'b1, 8'h55, 1'b0, 1'b0);
        cyc(1'b1, 8'hA3, 1'b0, 1'b0);
        cyc(1'b1, 8'h0F, 1'b0, 1'b0);
        chk("order_head", rd_data, 8'h55);
        repeat (3) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("order_empty", rd_valid, 1'b0);

        // push+pop on empty, overflow
        cyc(1'b1, 8'h3C, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_cnt", fifo_cnt, 3'd4);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b1, 8'h66, 1'b1, 1'b0);
        chk("ovf_pushpop", overflow, 1'b0);
        cyc(1'b1, 8'h77, 1'b0, 1'b1);
        chk("ovf_set_wins", overflow, 1'b1);
        repeat (4) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // break detect
        rx_in = 1'b0;
        n = -1;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (i == 2) chk("sync_delay", rx_sync, 1'b0);
            if (i == 1) chk("sync_hold", rx_sync, 1'b1);
            if (break_det) begin
                n = i;
                break;
            end
        end
        chk("brk_rise", n, 162);
        rx_in = 1'b1;
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (!break_det) begin
                n = i;
                break;
            end
        end
        chk("brk_fall", n, 3);
        rx_in = 1'b0;
        seen = 1'b0;
        for (int i = 1; i <= 110; i++) begin
            @(negedge clk);
            if (i == 100) rx_in = 1'b1;
            if (break_det) seen = 1'b1;
        end
        chk("brk_short", seen, 1'b0);

        // reset mid-operation
        cyc(1'b1, 8'h11, 1'b0, 1'b0);
        cyc(1'b1, 8'h22, 1'b0, 1'b0);
        cyc(1'b1, 8'h33, 1'b0, 1'b0);
        reset = 1'b0;
        rx_in = 1'b0;
        #2;
        chk("rst_noedge", fifo_cnt, 3'd3);
        @(negedge clk);
        reset = 1'b1;
        rx_in = 1'b1;
        q.delete();
        movf = 1'b0;
        chk("rst2_cnt", fifo_cnt, 0);
        chk("rst2_valid", rd_valid, 1'b0);
        chk("rst2_ovf", overflow, 1'b0);
        chk("rst2_tick", s_tick, 1'b0);
        chk("rst2_sync", rx_sync, 1'b1);

        // pointer wrap
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 8'(8'hE0 + i), 1'b1, 1'b0);
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        repeat (4) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("wrap_empty", rd_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
